// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I decode, EX..WB control pipeline, load-use stall, flush and hold.
// Optional CTRL_ILLEGAL_EN: flags unknown opcodes on illegal_o and bubbles them.
module pipe_ctrl_unit #(
    parameter int CTRL_DEPTH = 3,
    parameter int RA_W       = 5,
    parameter int CW         = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid_i,
    input  logic [6:0]                 id_opcode_i,
    input  logic [RA_W-1:0]            id_rs1_i,
    input  logic [RA_W-1:0]            id_rs2_i,
    input  logic [RA_W-1:0]            id_rd_i,
    input  logic                       flush_i,
    input  logic                       hold_i,
    output logic                       stall_o,
    output logic [CTRL_DEPTH*CW-1:0]   pipe_ctrl_o,
    output logic [CTRL_DEPTH*RA_W-1:0] pipe_rd_o,
    output logic [CTRL_DEPTH-1:0]      pipe_valid_o
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic                       illegal_o
`endif
);
    logic [CW-1:0]   raw_ctrl, dec_ctrl;
    logic            rs1_use, rs2_use, bubble;
    logic [CW-1:0]   ctrl_q [CTRL_DEPTH];
    logic [CW-1:0]   ctrl_d [CTRL_DEPTH];
    logic [RA_W-1:0] rd_q   [CTRL_DEPTH];
    logic [RA_W-1:0] rd_d   [CTRL_DEPTH];
    logic [CTRL_DEPTH-1:0] valid_q, valid_d;

    // bit 12 regwrite .. bit 3 pcsrc, [2:0] aluop
    always_comb begin
        raw_ctrl = '0;
        rs1_use  = 1'b0;
        rs2_use  = 1'b0;
        case (id_opcode_i)
            7'b0110011: begin raw_ctrl = 13'h1001; rs1_use = 1'b1; rs2_use = 1'b1; end
            7'b0010011: begin raw_ctrl = 13'h1022; rs1_use = 1'b1; end
            7'b0000011: begin raw_ctrl = 13'h18A3; rs1_use = 1'b1; end
            7'b0100011: begin raw_ctrl = 13'h0424; rs1_use = 1'b1; rs2_use = 1'b1; end
            7'b1100011: begin raw_ctrl = 13'h0205; rs1_use = 1'b1; rs2_use = 1'b1; end
            7'b1101111: raw_ctrl = 13'h1146;
            7'b1100111: begin raw_ctrl = 13'h114E; rs1_use = 1'b1; end
            7'b0110111: raw_ctrl = 13'h1037;
            7'b0010111: raw_ctrl = 13'h1027;
            default:    raw_ctrl = '0;
        endcase
    end

    assign dec_ctrl = id_valid_i ? {raw_ctrl[12] & (id_rd_i != '0), raw_ctrl[11:0]} : '0;

    assign stall_o = id_valid_i & valid_q[0] & ctrl_q[0][11] & (rd_q[0] != '0) &
                     ((rs1_use & (rd_q[0] == id_rs1_i)) | (rs2_use & (rd_q[0] == id_rs2_i))) &
                     ~flush_i;

`ifdef CTRL_ILLEGAL_EN
    logic illegal_d, illegal_q;
    // every legal opcode has a non-zero aluop, so an all-zero raw bundle means unknown
    assign illegal_d = id_valid_i & (raw_ctrl == '0) & ~flush_i & ~hold_i;
    assign bubble    = flush_i | stall_o | illegal_d;
    assign illegal_o = illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
`else
    assign bubble = flush_i | stall_o;
`endif

    always_comb begin
        ctrl_d[0]  = bubble ? '0 : dec_ctrl;
        rd_d[0]    = (bubble | ~id_valid_i) ? '0 : id_rd_i;
        valid_d[0] = id_valid_i & ~bubble;
        for (int k = 1; k < CTRL_DEPTH; k++) begin
            ctrl_d[k]  = ctrl_q[k-1];
            rd_d[k]    = rd_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '{default: '0};
            rd_q    <= '{default: '0};
            valid_q <= '0;
        end else if (!hold_i) begin
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < CTRL_DEPTH; g++) begin : g_out
        assign pipe_ctrl_o[g*CW +: CW]   = ctrl_q[g];
        assign pipe_rd_o[g*RA_W +: RA_W] = rd_q[g];
    end
    assign pipe_valid_o = valid_q;
endmodule
